seq_pattern_gen: RTL and testbench

//  Serial bit-pattern transmitter: the source side of our serial sequence detectors.
//  On a start request it shifts a fixed PAT_W-bit pattern out MSB-first, one bit per clock.
//  It repeats the pattern rep_count times, with gap_len idle cycles between repetitions.

---
 rtl/seq_pattern_gen.sv | 144 ++++++++++++++
 tb/tb_seq_pattern_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen
//   Serial bit-pattern transmitter. On an accepted start it shifts PATTERN out
//   MSB-first, one bit per clock, repeating it rep_count times. gap_len idle
//   cycles separate consecutive repetitions. Every output is registered.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-high reset
//   start       in   begin transmission (sampled only in IDLE)
//   abort       in   terminate transmission (wins over start)
//   rep_count   in   repetitions to send, latched on accepted start
//   gap_len     in   idle cycles between repetitions, latched on accepted start
//   bit_out     out  serial data bit, 0 whenever bit_valid is 0
//   bit_valid   out  bit_out carries a pattern bit this cycle
//   busy        out  transmission in progress (SEND or GAP)
//   done        out  one-cycle pulse after the last bit
//   sent_count  out  completed repetitions in the current or last run
//
// state | meaning
// IDLE  | waiting for start
// SEND  | shifting pattern bits out
// GAP   | idle spacing between repetitions
// DONE  | single-cycle completion pulse
module seq_pattern_gen #(
  parameter int                 PAT_W   = 4,
  parameter logic [PAT_W-1:0]   PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8,
  parameter int                 GAP_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] rep_count,
  input  logic [GAP_W-1:0] gap_len,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] rep_lat, rep_nxt;
  logic [GAP_W-1:0] gap_lat, gap_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic [CNT_W-1:0] sent_nxt;
  logic             bit_nxt, valid_nxt, busy_nxt, done_nxt;

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      rep_lat    <= '0;
      gap_lat    <= '0;
      gap_cnt    <= '0;
      sent_count <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      rep_lat    <= rep_nxt;
      gap_lat    <= gap_nxt;
      gap_cnt    <= gap_cnt_nxt;
      sent_count <= sent_nxt;
      bit_out    <= bit_nxt;
      bit_valid  <= valid_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    rep_nxt     = rep_lat;
    gap_nxt     = gap_lat;
    gap_cnt_nxt = gap_cnt;
    sent_nxt    = sent_count;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          rep_nxt   = rep_count;
          gap_nxt   = gap_len;
          sent_nxt  = '0;
          idx_nxt   = IDX_MSB;
          state_nxt = (rep_count != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (idx == '0) begin
          sent_nxt = sent_count + CNT_W'(1);
          if (sent_nxt == rep_lat) begin
            state_nxt = DONE;
          end else if (gap_lat != '0) begin
            state_nxt   = GAP;
            gap_cnt_nxt = gap_lat;
          end else begin
            // back-to-back repetition, no bubble
            idx_nxt = IDX_MSB;
          end
        end else begin
          idx_nxt = idx - IDX_W'(1);
        end
      end
      GAP: begin
        // gap_cnt loaded with gap_len on entry, so GAP lasts gap_len cycles
        if (abort) begin
          state_nxt = IDLE;
        end else if (gap_cnt == GAP_W'(1)) begin
          state_nxt = SEND;
          idx_nxt   = IDX_MSB;
        end else begin
          gap_cnt_nxt = gap_cnt - GAP_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in the register
  // on the same edge as the state they describe.
  always_comb begin
    valid_nxt = (state_nxt == SEND);
    bit_nxt   = valid_nxt & PATTERN[idx_nxt];
    busy_nxt  = (state_nxt == SEND) || (state_nxt == GAP);
    done_nxt  = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
module tb_seq_pattern_gen;

  localparam logic [3:0] PAT = 4'b1011;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] rep_count;
  logic [3:0] gap_len;
  logic       bit_out, bit_valid, busy, done;
  logic [7:0] sent_count;

  seq_pattern_gen dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rep_count(rep_count), .gap_len(gap_len),
    .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy), .done(done),
    .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic bo;
    logic bv;
    logic bsy;
    logic dn;
  } out_t;

  typedef struct {
    int rep;
    int gap;
    int exp_busy;
    int exp_sent;
  } vec_t;

  out_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input out_t e);
    out_t g;
    g = '{bit_out, bit_valid, busy, done};
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got bo/bv/busy/done=%b exp %b", name, g, e);
    end
  endtask

  // Expected per-cycle stream of a complete run, pushed when start is driven.
  task automatic push_run(input int rep, input int gap);
    logic [3:0] p;
    p = PAT;
    for (int r = 0; r < rep; r++) begin
      for (int b = 3; b >= 0; b--) sb.push_back('{p[b], 1'b1, 1'b1, 1'b0});
      if (r < rep - 1)
        for (int g = 0; g < gap; g++) sb.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
    end
    sb.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  // Drive a start at a negedge, then compare every cycle against the queue.
  task automatic run_vec(input string name, input int rep, input int gap,
                         input int exp_busy, input int exp_sent);
    int nbusy;
    int cyc;
    nbusy = 0;
    cyc = 0;
    @(negedge clk);
    start = 1'b1;
    rep_count = 8'(rep);
    gap_len = 4'(gap);
    push_run(rep, gap);
    @(negedge clk);
    start = 1'b0;
    while (sb.size() > 0 && cyc < 400) begin
      cyc++;
      if (busy) nbusy++;
      chk_out($sformatf("%s cyc%0d", name, cyc), sb.pop_front());
      @(negedge clk);
    end
    chk({name, " busy_cycles"}, nbusy, exp_busy);
    chk_out({name, " idle_after"}, '{1'b0, 1'b0, 1'b0, 1'b0});
    chk({name, " sent_count"}, sent_count, exp_sent);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1, 0, 4, 1};
    vecs[1] = '{3, 0, 12, 3};
    vecs[2] = '{2, 3, 11, 2};
    vecs[3] = '{2, 1, 9, 2};
    vecs[4] = '{1, 5, 4, 1};
    vecs[5] = '{2, 15, 23, 2};

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    rep_count = '0;
    gap_len = '0;
    #1;
    chk_out("reset_outputs", '{1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset_sent", sent_count, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_out("idle_after_reset", '{1'b0, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < 6; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].rep, vecs[i].gap,
              vecs[i].exp_busy, vecs[i].exp_sent);

    // Abort mid-run on cycle 6; a start on cycle 3 must be ignored.
    @(negedge clk);
    start = 1'b1; rep_count = 8'd4; gap_len = 4'd0;
    @(negedge clk);
    start = 1'b0;
    sb.delete();
    sb.push_back('{1'b1, 1'b1, 1'b1, 1'b0});
    sb.push_back('{1'b0, 1'b1, 1'b1, 1'b0});
    sb.push_back('{1'b1, 1'b1, 1'b1, 1'b0});
    sb.push_back('{1'b1, 1'b1, 1'b1, 1'b0});
    sb.push_back('{1'b1, 1'b1, 1'b1, 1'b0});
    sb.push_back('{1'b0, 1'b1, 1'b1, 1'b0});
    for (int c = 1; c <= 6; c++) begin
      chk_out($sformatf("abort cyc%0d", c), sb.pop_front());
      start = (c == 3);
      if (c == 3) begin rep_count = 8'd1; gap_len = 4'd5; end
      abort = (c == 6);
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0;
    for (int c = 7; c <= 9; c++) begin
      chk_out($sformatf("abort idle cyc%0d", c), '{1'b0, 1'b0, 1'b0, 1'b0});
      chk($sformatf("abort sent cyc%0d", c), sent_count, 1);
      @(negedge clk);
    end

    // rep_count == 0: done pulse only.
    run_vec("rep0", 0, 2, 0, 0);

    // start together with abort in IDLE: nothing happens.
    start = 1'b1; abort = 1'b1; rep_count = 8'd3; gap_len = 4'd0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk_out($sformatf("start_abort cyc%0d", c), '{1'b0, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
    end

    // Async reset between edges while in GAP.
    start = 1'b1; rep_count = 8'd2; gap_len = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk_out("pre_reset_gap", '{1'b0, 1'b0, 1'b1, 1'b0});
    #2 reset = 1'b1;
    #1;
    chk_out("async_reset_outputs", '{1'b0, 1'b0, 1'b0, 1'b0});
    chk("async_reset_sent", sent_count, 0);
    @(negedge clk);
    reset = 1'b0;
    run_vec("post_reset", 1, 0, 4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
